// File: rtl/divider_arbiter_pkg.sv
// Shared types and constants for the divider arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package divider_pkg;

  // Default operand/result width, matching the shared divider.
  localparam int WIDTH_DEF = 8;

  // Quotient returned on divide-by-zero: all ones, sliced to WIDTH by users.
  localparam logic [63:0] DZ_QUOTIENT = '1;

  // Arbiter sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/divider_arbiter_if.sv
// Bundles requester-side and divider-side signals of the divider arbiter.
// Latency: n/a (wiring only).
// Backpressure: requesters hold req/operands until grant; divider gates issue with div_idle.
interface divider_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
);

  // Requester side
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] n_in;
  logic [NUM_REQ*WIDTH-1:0] d_in;
  logic [NUM_REQ-1:0]       grant;
  logic [NUM_REQ-1:0]       done;
  logic [WIDTH-1:0]         q_out;
  logic [WIDTH-1:0]         r_out;
  logic                     dz_err;
  logic                     to_err;
  logic                     busy;

  // Divider side
  logic                     div_start;
  logic [WIDTH-1:0]         div_N;
  logic [WIDTH-1:0]         div_D;
  logic                     div_idle;
  logic                     div_finish;
  logic [WIDTH-1:0]         div_Q;
  logic [WIDTH-1:0]         div_R;

  // The arbiter serves requests and drives the divider.
  modport slave (
    input  req, n_in, d_in, div_idle, div_finish, div_Q, div_R,
    output grant, done, q_out, r_out, dz_err, to_err, busy,
           div_start, div_N, div_D
  );

  // Requesters plus the divider, seen from outside the arbiter.
  modport master (
    output req, n_in, d_in, div_idle, div_finish, div_Q, div_R,
    input  grant, done, q_out, r_out, dz_err, to_err, busy,
           div_start, div_N, div_D
  );

endinterface

// File: rtl/divider_arbiter_rr_arbiter.sv
// Round-robin priority pick: first asserted req at or after ptr, wrapping.
// Latency: combinational, zero cycles.
// Backpressure: none; any_o low when no request is pending.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  // Scan from ptr upward, modulo NUM_REQ, and stop at the first hit.
  always_comb begin
    int cand;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(ptr_i) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/divider_arbiter.sv
// Shares one divider among NUM_REQ requesters with round-robin arbitration.
// Latency: grant 1 cycle after req; done 1 cycle after div_finish rise (or after ISSUE on D==0).
// Backpressure: no issue while div_idle=0; watchdog aborts after TIMEOUT_CYC WAIT cycles.
module divider_arbiter
  import divider_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int WIDTH       = WIDTH_DEF,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        CLK,
  input  logic        reset,
  divider_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYC);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [WIDTH-1:0] DZ_Q      = DZ_QUOTIENT[WIDTH-1:0];

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   win_idx_q, win_idx_d;
  logic [WIDTH-1:0]   div_n_q, div_n_d;
  logic [WIDTH-1:0]   div_d_q, div_d_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   r_q, r_d;
  logic               dz_q, dz_d;
  logic               to_q, to_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               fin_prev_q;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;
  logic [WIDTH-1:0]   n_sel;
  logic [WIDTH-1:0]   d_sel;
  logic               fin_rise;
  logic               timeout_hit;
  logic               accept;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req_i (bus.req),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  // AND-OR select of the winner's operands from the packed request buses.
  always_comb begin
    n_sel = '0;
    d_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) begin
        n_sel = n_sel | bus.n_in[i*WIDTH +: WIDTH];
        d_sel = d_sel | bus.d_in[i*WIDTH +: WIDTH];
      end
    end
  end

  // Only a rising finish counts, so a divider holding finish high cannot retrigger.
  assign fin_rise    = bus.div_finish & ~fin_prev_q;
  assign timeout_hit = (cnt_q == CNT_LIMIT);
  assign accept      = (state_q == IDLE) && arb_any && bus.div_idle;

  // State register.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; a finish in the timeout cycle takes precedence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   state_d = (div_d_q == '0) ? RESP : WAIT;
      WAIT:    if (fin_rise || timeout_hit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: operand latch, watchdog count, result capture, flags.
  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    win_idx_d = win_idx_q;
    div_n_d   = div_n_q;
    div_d_d   = div_d_q;
    q_d       = q_q;
    r_d       = r_q;
    dz_d      = dz_q;
    to_d      = to_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          win_idx_d = arb_idx;
          rr_ptr_d  = (arb_idx == LAST_IDX) ? '0 : arb_idx + IDX_W'(1);
          div_n_d   = n_sel;
          div_d_d   = d_sel;
        end
      end
      ISSUE: begin
        cnt_d = '0;
        if (div_d_q == '0) begin
          q_d  = DZ_Q;
          r_d  = div_n_q;
          dz_d = 1'b1;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (fin_rise) begin
          q_d = bus.div_Q;
          r_d = bus.div_R;
        end else if (timeout_hit) begin
          q_d  = '0;
          r_d  = '0;
          to_d = 1'b1;
        end
      end
      RESP: begin
        dz_d = 1'b0;
        to_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Datapath registers; reset clears everything so an aborted op leaves no trace.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      rr_ptr_q   <= '0;
      win_idx_q  <= '0;
      div_n_q    <= '0;
      div_d_q    <= '0;
      q_q        <= '0;
      r_q        <= '0;
      dz_q       <= 1'b0;
      to_q       <= 1'b0;
      cnt_q      <= '0;
      fin_prev_q <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      win_idx_q  <= win_idx_d;
      div_n_q    <= div_n_d;
      div_d_q    <= div_d_d;
      q_q        <= q_d;
      r_q        <= r_d;
      dz_q       <= dz_d;
      to_q       <= to_d;
      cnt_q      <= cnt_d;
      fin_prev_q <= bus.div_finish;
    end
  end

  // Output decode: grant/start pulse in ISSUE, done pulse in RESP.
  always_comb begin
    bus.grant     = '0;
    bus.done      = '0;
    bus.div_start = 1'b0;
    bus.busy      = (state_q != IDLE);
    if (state_q == ISSUE) begin
      bus.grant     = NUM_REQ'(1) << win_idx_q;
      bus.div_start = (div_d_q != '0);
    end
    if (state_q == RESP) begin
      bus.done = NUM_REQ'(1) << win_idx_q;
    end
    bus.q_out  = q_q;
    bus.r_out  = r_q;
    bus.dz_err = dz_q;
    bus.to_err = to_q;
    bus.div_N  = div_n_q;
    bus.div_D  = div_d_q;
  end

endmodule
